// File: rtl/data_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_bridge
// Purpose  : CPU memory-stage to synchronous data SRAM bridge. Stores issue in
//            the same cycle; loads take 3 cycles (IDLE, RD_WAIT, RD_DONE).
//            Optional alignment rejection: define DSRAM_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module data_sram_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_ce,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_lsop,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stallreq,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    output logic        misalign
);

    localparam logic [3:0] c_LB  = 4'd1;
    localparam logic [3:0] c_LBU = 4'd2;
    localparam logic [3:0] c_LH  = 4'd3;
    localparam logic [3:0] c_LHU = 4'd4;
    localparam logic [3:0] c_LW  = 4'd5;
    localparam logic [3:0] c_SB  = 4'd6;
    localparam logic [3:0] c_SH  = 4'd7;
    localparam logic [3:0] c_SW  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RD_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_lsop;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_rdata_q;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misal_raw;
    logic        w_idle_req;
    logic        w_ld_go;
    logic        w_st_go;
    logic [3:0]  w_strobe;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic        w_unused_we;

    // Store/load direction comes from the opcode alone; cpu_we is redundant.
    assign w_unused_we = cpu_we;

    assign w_is_load  = (cpu_lsop >= c_LB) && (cpu_lsop <= c_LW);
    assign w_is_store = (cpu_lsop >= c_SB) && (cpu_lsop <= c_SW);
    assign w_is_half  = (cpu_lsop == c_LH) || (cpu_lsop == c_LHU) || (cpu_lsop == c_SH);
    assign w_is_word  = (cpu_lsop == c_LW) || (cpu_lsop == c_SW);

`ifdef DSRAM_ALIGN_CHECK_EN
    assign w_misal_raw = (w_is_half && cpu_addr[0]) || (w_is_word && (cpu_addr[1:0] != 2'b00));
`else
    assign w_misal_raw = 1'b0;
`endif

    // Gating with resetn keeps every request output low while reset is held.
    assign w_idle_req = resetn && (r_state == S_IDLE) && cpu_ce;
    assign w_ld_go    = w_idle_req && w_is_load  && !w_misal_raw;
    assign w_st_go    = w_idle_req && w_is_store && !w_misal_raw;

    assign misalign       = w_idle_req && (w_is_load || w_is_store) && w_misal_raw;
    assign stallreq       = w_ld_go || (resetn && (r_state == S_RD_WAIT));
    assign data_sram_en   = w_ld_go || w_st_go;
    assign data_sram_wen  = w_st_go ? w_strobe : 4'b0000;
    assign data_sram_addr = {cpu_addr[31:2], 2'b00};
    assign cpu_rdata      = r_rdata_q;

    always_comb begin
        w_strobe        = 4'b1111;
        data_sram_wdata = cpu_wdata;
        if (cpu_lsop == c_SB) begin
            w_strobe        = 4'b0001 << cpu_addr[1:0];
            data_sram_wdata = {4{cpu_wdata[7:0]}};
        end else if (cpu_lsop == c_SH) begin
            w_strobe        = cpu_addr[1] ? 4'b1100 : 4'b0011;
            data_sram_wdata = {2{cpu_wdata[15:0]}};
        end
    end

    always_comb begin
        case (r_addr_lo)
            2'd0:    w_byte = data_sram_rdata[7:0];
            2'd1:    w_byte = data_sram_rdata[15:8];
            2'd2:    w_byte = data_sram_rdata[23:16];
            default: w_byte = data_sram_rdata[31:24];
        endcase
        w_half = r_addr_lo[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
        case (r_lsop)
            c_LB:    w_ext = {{24{w_byte[7]}}, w_byte};
            c_LBU:   w_ext = {24'd0, w_byte};
            c_LH:    w_ext = {{16{w_half[15]}}, w_half};
            c_LHU:   w_ext = {16'd0, w_half};
            default: w_ext = data_sram_rdata;
        endcase
    end

    // RD_DONE ignores CPU inputs so the still-held load is not re-issued.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_lsop    <= 4'd0;
            r_addr_lo <= 2'd0;
            r_rdata_q <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ld_go) begin
                        r_lsop    <= cpu_lsop;
                        r_addr_lo <= cpu_addr[1:0];
                        r_state   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    r_rdata_q <= w_ext;
                    r_state   <= S_RD_DONE;
                end
                S_RD_DONE: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_sram_bridge
// Purpose  : Directed self-checking bench for data_sram_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_ce;
    logic        cpu_we;
    logic [3:0]  cpu_lsop;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stallreq;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4, LW = 4'd5;
    localparam logic [3:0] SB = 4'd6, SH = 4'd7, SW = 4'd8;
    localparam logic [31:0] JUNK = 32'hBAD0BAD0;

    always #5 clk = ~clk;

    data_sram_bridge dut (
        .clk(clk), .resetn(resetn),
        .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_lsop(cpu_lsop),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .stallreq(stallreq),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .misalign(misalign)
    );

    task automatic idle_inputs();
        cpu_ce = 1'b0; cpu_we = 1'b0; cpu_lsop = 4'd0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; data_sram_rdata = JUNK;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0; cpu_ce = 1'b1; cpu_lsop = LW; cpu_addr = 32'h2002;
        #1;
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", stallreq); end
        checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b exp 0", data_sram_en); end
        checks++; if (data_sram_wen !== 4'h0) begin errors++; $display("FAIL rst_wen: got %h exp 0", data_sram_wen); end
        checks++; if (cpu_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", cpu_rdata); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b exp 0", misalign); end
        @(negedge clk);
        resetn = 1'b1; idle_inputs();
    endtask

    task automatic test_idle();
        @(negedge clk);
        cpu_ce = 1'b0; cpu_we = 1'b1; cpu_lsop = SW; cpu_addr = 32'h1000;
        #1;
        checks++; if (data_sram_en !== 1'b0 || data_sram_wen !== 4'h0)
            begin errors++; $display("FAIL idle_ce0: got en=%b wen=%h exp 0/0", data_sram_en, data_sram_wen); end
        @(negedge clk);
        cpu_ce = 1'b1; cpu_lsop = 4'd9;
        #1;
        checks++; if (data_sram_en !== 1'b0 || data_sram_wen !== 4'h0 || stallreq !== 1'b0)
            begin errors++; $display("FAIL idle_op9: got en=%b wen=%h stall=%b exp 0", data_sram_en, data_sram_wen, stallreq); end
        idle_inputs();
    endtask

    task automatic test_store();
        logic [3:0]  op  [6];
        logic [31:0] ad  [6];
        logic [31:0] wd  [6];
        logic [3:0]  ewn [6];
        logic [31:0] ewd [6];
        op[0]=SW; ad[0]=32'h1004; wd[0]=32'hDEADBEEF; ewn[0]=4'hF; ewd[0]=32'hDEADBEEF;
        op[1]=SB; ad[1]=32'h1003; wd[1]=32'h000000A5; ewn[1]=4'h8; ewd[1]=32'hA5A5A5A5;
        op[2]=SH; ad[2]=32'h1002; wd[2]=32'h00001234; ewn[2]=4'hC; ewd[2]=32'h12341234;
        op[3]=SB; ad[3]=32'h1000; wd[3]=32'hFFFFFF5A; ewn[3]=4'h1; ewd[3]=32'h5A5A5A5A;
        op[4]=SH; ad[4]=32'h1000; wd[4]=32'h7777ABCD; ewn[4]=4'h3; ewd[4]=32'hABCDABCD;
        op[5]=SB; ad[5]=32'h1001; wd[5]=32'h0000003C; ewn[5]=4'h2; ewd[5]=32'h3C3C3C3C;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cpu_ce = 1'b1; cpu_we = 1'b1; cpu_lsop = op[i]; cpu_addr = ad[i]; cpu_wdata = wd[i];
            #1;
            checks++; if (data_sram_en !== 1'b1 || stallreq !== 1'b0)
                begin errors++; $display("FAIL st%0d_en_stall: got en=%b stall=%b exp 1/0", i, data_sram_en, stallreq); end
            checks++; if (data_sram_wen !== ewn[i])
                begin errors++; $display("FAIL st%0d_wen: got %h exp %h", i, data_sram_wen, ewn[i]); end
            checks++; if (data_sram_wdata !== ewd[i])
                begin errors++; $display("FAIL st%0d_wdata: got %h exp %h", i, data_sram_wdata, ewd[i]); end
            checks++; if (data_sram_addr !== {ad[i][31:2], 2'b00})
                begin errors++; $display("FAIL st%0d_addr: got %h exp %h", i, data_sram_addr, {ad[i][31:2], 2'b00}); end
        end
        idle_inputs();
    endtask

    task automatic test_load(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] word, input logic [31:0] exp);
        @(negedge clk);
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_lsop = op; cpu_addr = addr; data_sram_rdata = JUNK;
        #1;
        checks++; if (data_sram_en !== 1'b1 || data_sram_wen !== 4'h0 || stallreq !== 1'b1 || misalign !== 1'b0)
            begin errors++; $display("FAIL ld%0d_c0: got en=%b wen=%h stall=%b mis=%b exp 1/0/1/0", op, data_sram_en, data_sram_wen, stallreq, misalign); end
        checks++; if (data_sram_addr !== {addr[31:2], 2'b00})
            begin errors++; $display("FAIL ld%0d_addr: got %h exp %h", op, data_sram_addr, {addr[31:2], 2'b00}); end
        @(negedge clk);
        data_sram_rdata = word;
        #1;
        checks++; if (stallreq !== 1'b1 || data_sram_en !== 1'b0)
            begin errors++; $display("FAIL ld%0d_c1: got stall=%b en=%b exp 1/0", op, stallreq, data_sram_en); end
        @(negedge clk);
        data_sram_rdata = JUNK;
        #1;
        checks++; if (stallreq !== 1'b0 || data_sram_en !== 1'b0)
            begin errors++; $display("FAIL ld%0d_c2: got stall=%b en=%b exp 0/0", op, stallreq, data_sram_en); end
        checks++; if (cpu_rdata !== exp)
            begin errors++; $display("FAIL ld%0d_rdata: got %h exp %h", op, cpu_rdata, exp); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (cpu_rdata !== exp)
            begin errors++; $display("FAIL ld%0d_hold: got %h exp %h", op, cpu_rdata, exp); end
    endtask

    task automatic test_back_to_back();
        int en_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cpu_ce = 1'b1; cpu_we = 1'b0; cpu_lsop = LW; cpu_addr = 32'h4000;
            data_sram_rdata = (i == 1) ? 32'h13572468 : (i == 4) ? 32'h9ABCDEF0 : JUNK;
            #1;
            if (data_sram_en === 1'b1) en_cnt++;
            checks++; if (data_sram_en !== (i % 3 == 0) || stallreq !== (i % 3 != 2))
                begin errors++; $display("FAIL b2b_c%0d: got en=%b stall=%b exp %b/%b", i, data_sram_en, stallreq, (i % 3 == 0), (i % 3 != 2)); end
            if (i == 2) begin
                checks++; if (cpu_rdata !== 32'h13572468)
                    begin errors++; $display("FAIL b2b_rd1: got %h exp 13572468", cpu_rdata); end
            end
            if (i == 5) begin
                checks++; if (cpu_rdata !== 32'h9ABCDEF0)
                    begin errors++; $display("FAIL b2b_rd2: got %h exp 9abcdef0", cpu_rdata); end
            end
        end
        checks++; if (en_cnt != 2) begin errors++; $display("FAIL b2b_en_count: got %0d exp 2", en_cnt); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_midload();
        @(negedge clk);
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_lsop = LW; cpu_addr = 32'h5000; data_sram_rdata = JUNK;
        @(negedge clk);
        data_sram_rdata = 32'h77777777;
        resetn = 1'b0;
        #1;
        checks++; if (stallreq !== 1'b0 || data_sram_en !== 1'b0 || data_sram_wen !== 4'h0)
            begin errors++; $display("FAIL mid_rst_ctl: got stall=%b en=%b wen=%h exp 0", stallreq, data_sram_en, data_sram_wen); end
        checks++; if (cpu_rdata !== 32'd0)
            begin errors++; $display("FAIL mid_rst_rdata: got %h exp 0", cpu_rdata); end
        @(negedge clk);
        resetn = 1'b1;
        cpu_we = 1'b1; cpu_lsop = SW; cpu_addr = 32'h5008; cpu_wdata = 32'hCAFEF00D;
        #1;
        checks++; if (data_sram_en !== 1'b1 || data_sram_wen !== 4'hF || stallreq !== 1'b0 || data_sram_wdata !== 32'hCAFEF00D)
            begin errors++; $display("FAIL post_rst_sw: got en=%b wen=%h stall=%b wd=%h exp 1/f/0/cafef00d", data_sram_en, data_sram_wen, stallreq, data_sram_wdata); end
        idle_inputs();
    endtask

    task automatic test_misalign();
`ifdef DSRAM_ALIGN_CHECK_EN
        logic [3:0]  op [3];
        logic [31:0] ad [3];
        op[0] = LW; ad[0] = 32'h3002;
        op[1] = SW; ad[1] = 32'h3001;
        op[2] = LH; ad[2] = 32'h3001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpu_ce = 1'b1; cpu_we = (op[i] == SW); cpu_lsop = op[i]; cpu_addr = ad[i];
            #1;
            checks++; if (misalign !== 1'b1 || data_sram_en !== 1'b0 || data_sram_wen !== 4'h0 || stallreq !== 1'b0)
                begin errors++; $display("FAIL mis%0d: got mis=%b en=%b wen=%h stall=%b exp 1/0/0/0", i, misalign, data_sram_en, data_sram_wen, stallreq); end
        end
        @(negedge clk);
        cpu_we = 1'b1; cpu_lsop = SW; cpu_addr = 32'h3000;
        #1;
        checks++; if (misalign !== 1'b0 || data_sram_en !== 1'b1 || data_sram_wen !== 4'hF)
            begin errors++; $display("FAIL mis_after: got mis=%b en=%b wen=%h exp 0/1/f", misalign, data_sram_en, data_sram_wen); end
        idle_inputs();
`else
        test_load(LW, 32'h3002, 32'h11223344, 32'h11223344);
        test_load(LH, 32'h3003, 32'h8765ABCD, 32'hFFFF8765);
        @(negedge clk);
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_lsop = SH; cpu_addr = 32'h1003; cpu_wdata = 32'h0000BEEF;
        #1;
        checks++; if (misalign !== 1'b0 || data_sram_wen !== 4'hC || data_sram_wdata !== 32'hBEEFBEEF)
            begin errors++; $display("FAIL unaligned_sh: got mis=%b wen=%h wd=%h exp 0/c/beefbeef", misalign, data_sram_wen, data_sram_wdata); end
        idle_inputs();
`endif
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        test_reset();
        test_idle();
        test_store();
        test_load(LB,  32'h2001, 32'h00008000, 32'hFFFFFF80);
        test_load(LBU, 32'h2001, 32'h00008000, 32'h00000080);
        test_load(LH,  32'h2002, 32'h80010000, 32'hFFFF8001);
        test_load(LHU, 32'h2002, 32'h80010000, 32'h00008001);
        test_load(LW,  32'h2000, 32'h80010000, 32'h80010000);
        test_load(LB,  32'h2003, 32'h7F000000, 32'h0000007F);
        test_back_to_back();
        test_reset_midload();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
